// File: rtl/shift_left2.sv
// shift_left2: logical shift-left by SHAMT (x4 by default) for MIPS address
// generation. Provides a zero-latency combinational path (a -> y) and a
// registered ready/valid path with a 2-entry skid buffer (in_* -> out_*).
// Results on the registered path are computed at capture time and stored
// already shifted, together with their overflow bit.

module shift_left2 #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             y_ovf,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  // Shifted word: discard the top SHAMT bits, zero-fill the bottom SHAMT bits.
  function automatic logic [WIDTH-1:0] shl_f(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
  endfunction

  // Overflow: any bit shifted out of the word was set.
  function automatic logic ovf_f(input logic [WIDTH-1:0] v);
    return |v[WIDTH-1:WIDTH-SHAMT];
  endfunction

  // Combinational path: independent of clk and reset.
  assign y     = shl_f(a);
  assign y_ovf = ovf_f(a);

  // Registered-path state.
  logic [WIDTH-1:0] out_data_r;
  logic             out_ovf_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             skid_ovf_r;
  logic             skid_valid_r;
  logic             in_ready_r;

  // Next-state values.
  logic [WIDTH-1:0] out_data_s;
  logic             out_ovf_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             skid_ovf_s;
  logic             skid_valid_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_free_s;

  // Next-state logic for the output register and the skid register.
  always_comb begin
    out_data_s   = out_data_r;
    out_ovf_s    = out_ovf_r;
    out_valid_s  = out_valid_r;
    skid_data_s  = skid_data_r;
    skid_ovf_s   = skid_ovf_r;
    skid_valid_s = skid_valid_r;
    in_xfer_s    = in_valid && in_ready_r;
    out_free_s   = !out_valid_r || out_ready;

    if (out_free_s) begin
      if (skid_valid_r) begin
        // Oldest word lives in the skid register; promote it first.
        out_data_s   = skid_data_r;
        out_ovf_s    = skid_ovf_r;
        out_valid_s  = 1'b1;
        skid_valid_s = 1'b0;
      end else if (in_xfer_s) begin
        out_data_s  = shl_f(in_data);
        out_ovf_s   = ovf_f(in_data);
        out_valid_s = 1'b1;
      end else begin
        // Nothing to present; data/ovf keep their last value.
        out_valid_s = 1'b0;
      end
    end else begin
      if (in_xfer_s) begin
        // Output stalled: park the incoming word in the skid register.
        skid_data_s  = shl_f(in_data);
        skid_ovf_s   = ovf_f(in_data);
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end

    // Registered ready: reflects next-cycle skid occupancy only.
    in_ready_s = !skid_valid_s;
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r   <= {WIDTH{1'b0}};
      out_ovf_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_ovf_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      out_data_r   <= out_data_s;
      out_ovf_r    <= out_ovf_s;
      out_valid_r  <= out_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ovf_r   <= skid_ovf_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= in_ready_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_shift_left2.sv
// Self-checking bench for shift_left2: directed scenarios plus a randomized
// stream checked against an arithmetic reference model and an ordered queue.

module tb_shift_left2;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] y;
  logic        y_ovf;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  int total;
  int bad;

  shift_left2 #(.WIDTH(32), .SHAMT(2)) dut (
    .clk(clk), .reset(reset), .a(a), .y(y), .y_ovf(y_ovf),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: multiply by four and keep 32 bits.
  function automatic logic [31:0] ref_y(input logic [31:0] v);
    longint unsigned p;
    p = longint'(v) * 64'd4;
    return p[31:0];
  endfunction

  // Reference overflow: the product does not fit in 32 bits.
  function automatic logic ref_ovf(input logic [31:0] v);
    return (v >= 32'h4000_0000);
  endfunction

  logic [31:0] tab_a [7] = '{32'h00000001, 32'h00000003, 32'h000000FF, 32'h0000FFFF,
                             32'hFFFFFFFF, 32'h12345678, 32'h87653321};
  logic [31:0] tab_y [7] = '{32'h00000004, 32'h0000000C, 32'h000003FC, 32'h0003FFFC,
                             32'hFFFFFFFC, 32'h48D159E0, 32'h1D94CC84};
  logic        tab_o [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hFFFFFFFF; out_ready = 1'b0;
    a = 32'h12345678;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    total++; if (y !== 32'h48D159E0) begin bad++; $display("FAIL reset_y got=%h exp=48d159e0", y); end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_comb();
    for (int i = 0; i < 7; i++) begin
      a = tab_a[i];
      #1;
      total++; if (y !== tab_y[i]) begin bad++; $display("FAIL comb_y[%0d] got=%h exp=%h", i, y, tab_y[i]); end
      total++; if (y_ovf !== tab_o[i]) begin bad++; $display("FAIL comb_ovf[%0d] got=%b exp=%b", i, y_ovf, tab_o[i]); end
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      #1;
      total++; if (y !== ref_y(a) || y_ovf !== ref_ovf(a)) begin
        bad++; $display("FAIL comb_rand a=%h got=%h/%b exp=%h/%b", a, y, y_ovf, ref_y(a), ref_ovf(a));
      end
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = tab_a[i];
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== tab_y[i] || out_ovf !== tab_o[i]) begin
        bad++; $display("FAIL stream[%0d] got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_ovf, tab_y[i], tab_o[i]);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h48D159E0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_first got=%b/%h rdy=%b exp=1/48d159e0 rdy=1", out_valid, out_data, in_ready);
    end
    in_data = 32'h87653321;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h48D159E0 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL bp_hold got=%b/%h/%b exp=1/48d159e0/0", out_valid, out_data, out_ovf);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    tick();
    total++; if (out_data !== 32'h48D159E0) begin bad++; $display("FAIL bp_hold2 got=%h exp=48d159e0", out_data); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h1D94CC84 || out_ovf !== 1'b1) begin
      bad++; $display("FAIL bp_second got=%b/%h/%b exp=1/1d94cc84/1", out_valid, out_data, out_ovf);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h00000001; tick();
    in_data = 32'h00000003; tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_skid_full got=%b exp=0", in_ready); end
    reset = 1'b1; in_data = 32'h0000FFFF;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ghost[%0d] got=%b/%h exp=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int          sent;
    int          cyc;
    logic        stalled;
    logic [31:0] held_data;
    logic        held_ovf;
    sent = 0; cyc = 0; stalled = 1'b0; held_data = 32'h0; held_ovf = 1'b0;
    while ((sent < 1000 || q.size() != 0) && cyc < 8000) begin
      if (out_valid) begin
        total++; if (q.size() == 0 || out_data !== q[0] || out_ovf !== ref_ovf_of(q[0])) begin
          bad++; $display("FAIL rand_data cyc=%0d got=%h/%b exp=%h", cyc, out_data, out_ovf, (q.size() != 0) ? q[0] : 32'h0);
        end
      end
      if (stalled) begin
        total++; if (out_valid !== 1'b1 || out_data !== held_data || out_ovf !== held_ovf) begin
          bad++; $display("FAIL rand_stable cyc=%0d got=%h exp=%h", cyc, out_data, held_data);
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) begin q.push_back(ref_y(in_data)); sent++; end
      stalled = out_valid && !out_ready;
      held_data = out_data; held_ovf = out_ovf;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (sent < 1000 || q.size() != 0) begin
      bad++; $display("FAIL rand_complete sent=%0d left=%0d exp=1000/0", sent, q.size());
    end
  endtask

  // Overflow of the original operand, recovered from its scaled value: the
  // queue stores x*4 mod 2^32, so keep a parallel map instead.
  logic ovf_map [logic [31:0]];
  function automatic logic ref_ovf_of(input logic [31:0] yv);
    return ovf_map.exists(yv) ? ovf_map[yv] : 1'bx;
  endfunction

  // Record each random operand's overflow keyed by its scaled value; a key
  // collision between two operands with differing overflow is marked x-free
  // by remembering the latest one, so the data check alone still applies.
  always @(posedge clk) begin
    if (in_valid && in_ready && !reset) ovf_map[ref_y(in_data)] = ref_ovf(in_data);
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; a = 32'h0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    test_reset();
    test_comb();
    test_stream();
    test_back_pressure();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
